// File: rtl/gaosi_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a shifting 3x3 register window,
// with per-row and per-frame marker pulses for the downstream filter/controller.
module gaosi_window_gen #(
  parameter int DATA_W = 8,
  parameter int LINE_W = 320,
  parameter int LINES  = 240
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sof,
  input  logic                  pix_valid,
  input  logic [DATA_W-1:0]     pix_data,
  output logic [9*DATA_W-1:0]   win,
  output logic                  win_valid,
  output logic [8:0]            win_col,
  output logic                  row_update,
  output logic                  frame_done
);

  localparam int CW = $clog2(LINE_W);
  localparam int RW = $clog2(LINES);
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(LINES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [CW-1:0]       col;
  logic [RW-1:0]       row;
  logic [DATA_W-1:0]   lb0 [LINE_W];
  logic [DATA_W-1:0]   lb1 [LINE_W];

  logic                accept;
  logic                last_pix;
  logic                interior;
  logic [CW-1:0]       c_cur;
  logic [RW-1:0]       r_cur;
  logic [DATA_W-1:0]   lb0_rd;
  logic [DATA_W-1:0]   lb1_rd;
  logic [9*DATA_W-1:0] win_next;

  // A pixel arriving together with sof is pixel (0,0) of the new frame.
  assign accept   = pix_valid && (sof || state == RUN);
  assign c_cur    = sof ? '0 : col;
  assign r_cur    = sof ? '0 : row;
  assign last_pix = (r_cur == ROW_LAST) && (c_cur == COL_LAST);
  assign interior = (r_cur >= RW'(2)) && (c_cur >= CW'(2));
  assign lb0_rd   = lb0[c_cur];
  assign lb1_rd   = lb1[c_cur];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_shift
      assign win_next[DATA_W*(3*gi+0) +: DATA_W] = win[DATA_W*(3*gi+1) +: DATA_W];
      assign win_next[DATA_W*(3*gi+1) +: DATA_W] = win[DATA_W*(3*gi+2) +: DATA_W];
    end
  endgenerate
  assign win_next[DATA_W*2 +: DATA_W] = lb1_rd;
  assign win_next[DATA_W*5 +: DATA_W] = lb0_rd;
  assign win_next[DATA_W*8 +: DATA_W] = pix_data;

  // Line buffers carry no reset; every entry is rewritten before it reaches a valid window.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[c_cur] <= lb0_rd;
      lb0[c_cur] <= pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      col        <= '0;
      row        <= '0;
      win        <= '0;
      win_valid  <= 1'b0;
      win_col    <= '0;
      row_update <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= accept && interior;
      row_update <= accept && interior && (c_cur == COL_LAST);
      frame_done <= accept && last_pix;

      if (accept && last_pix)
        state <= DONE;
      else if (sof)
        state <= RUN;

      if (accept) begin
        win <= win_next;
        if (interior)
          win_col <= 9'(c_cur) - 9'd1;
        if (c_cur == COL_LAST) begin
          col <= '0;
          row <= last_pix ? '0 : r_cur + RW'(1);
        end else begin
          col <= c_cur + CW'(1);
          row <= r_cur;
        end
      end else if (sof) begin
        col <= '0;
        row <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gaosi_window_gen.sv
// Directed bench for gaosi_window_gen with LINE_W=8, LINES=6 and pixel value r*16+c (+ optional base).
module tb_gaosi_window_gen;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int LN = 6;
  localparam int NWIN = (LW - 2) * (LN - 2);

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sof = 1'b0;
  logic            pix_valid = 1'b0;
  logic [DW-1:0]   pix_data = '0;
  logic [9*DW-1:0] win;
  logic            win_valid;
  logic [8:0]      win_col;
  logic            row_update;
  logic            frame_done;

  gaosi_window_gen #(.DATA_W(DW), .LINE_W(LW), .LINES(LN)) dut (
    .clk(clk), .rst_n(rst_n), .sof(sof), .pix_valid(pix_valid), .pix_data(pix_data),
    .win(win), .win_valid(win_valid), .win_col(win_col),
    .row_update(row_update), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9*DW-1:0] win;
    logic [8:0]      col;
    logic            ru;
  } vec_t;

  vec_t       tbl [NWIN];
  int         errors = 0;
  int         checks = 0;
  int         widx = 0;
  int         ru_cnt = 0;
  int         fd_cnt = 0;
  bit         mon_en = 1'b0;
  bit         quiet = 1'b0;
  logic [7:0] cur_base = 8'h00;
  logic       pv_prev = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clk) pv_prev <= pix_valid;

  always @(negedge clk) begin
    if (mon_en) begin
      if (win_valid) begin
        chk("valid_has_accept", 128'(pv_prev), 128'(1));
        if (widx >= NWIN) begin
          chk("win_count_overflow", 128'(widx), 128'(NWIN - 1));
        end else begin
          chk($sformatf("win[%0d]", widx), 128'(win), 128'(tbl[widx].win | {9{cur_base}}));
          chk($sformatf("win_col[%0d]", widx), 128'(win_col), 128'(tbl[widx].col));
          chk($sformatf("row_update[%0d]", widx), 128'(row_update), 128'(tbl[widx].ru));
          $display("window %0d col=%0d ru=%0b win=%h", widx, win_col, row_update, win);
        end
        widx++;
        if (row_update) ru_cnt++;
      end else if (row_update) begin
        chk("row_update_without_valid", 128'(row_update), 128'(0));
      end
      if (frame_done) fd_cnt++;
      if (quiet)
        chk("quiet_outputs", 128'({win_valid, row_update, frame_done}), 128'(0));
    end
  end

  task automatic idle(input int n);
    pix_valid = 1'b0;
    sof = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input logic [DW-1:0] d, input logic s);
    pix_valid = 1'b1;
    pix_data  = d;
    sof       = s;
    @(posedge clk);
    #1;
    sof       = 1'b0;
    pix_valid = 1'b0;
  endtask

  // Sends pixels k=0..npix-1 in raster order; first one optionally with sof.
  task automatic send(input int npix, input logic [7:0] base, input bit gaps, input bit with_sof);
    for (int k = 0; k < npix; k++) begin
      if (gaps) begin
        while ($urandom_range(1, 0) == 1) idle(1);
      end
      drive(8'((k / LW) * 16 + (k % LW)) | base, (k == 0) && with_sof);
    end
  endtask

  task automatic start_count(input logic [7:0] base);
    widx = 0;
    ru_cnt = 0;
    fd_cnt = 0;
    cur_base = base;
  endtask

  task automatic full_frame(input string tag, input logic [7:0] base, input bit gaps);
    start_count(base);
    send(LW * LN, base, gaps, 1'b1);
    chk({tag, "_frame_done_pulse"}, 128'(frame_done), 128'(1));
    idle(1);
    chk({tag, "_frame_done_drop"}, 128'(frame_done), 128'(0));
    chk({tag, "_win_count"}, 128'(widx), 128'(NWIN));
    chk({tag, "_ru_count"}, 128'(ru_cnt), 128'(LN - 2));
    chk({tag, "_fd_count"}, 128'(fd_cnt), 128'(1));
  endtask

  initial begin
    for (int r = 2; r < LN; r++) begin
      for (int c = 2; c < LW; c++) begin
        int n;
        n = (r - 2) * (LW - 2) + (c - 2);
        tbl[n].win = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            tbl[n].win[DW*(3*i+j) +: DW] = 8'((r - 2 + i) * 16 + (c - 2 + j));
        tbl[n].col = 9'(c - 1);
        tbl[n].ru  = (c == LW - 1);
      end
    end
    chk("table_first_window", 128'(tbl[0].win), 128'(72'h22_21_20_12_11_10_02_01_00));

    // Reset and idle: valid pixels without sof must not produce anything.
    idle(3);
    rst_n = 1'b1;
    idle(1);
    chk("reset_outputs", 128'({win, win_valid, win_col, row_update, frame_done}), 128'(0));
    mon_en = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 20; k++) drive(8'(k), 1'b0);
    quiet = 1'b0;
    chk("idle_win_zero", 128'({win, win_col}), 128'(0));

    full_frame("cont", 8'h00, 1'b0);
    full_frame("gaps", 8'h00, 1'b1);

    // Pixels after the frame end are ignored until the next sof.
    quiet = 1'b1;
    for (int k = 0; k < 10; k++) drive(8'hee, 1'b0);
    idle(1);
    quiet = 1'b0;
    full_frame("second", 8'h00, 1'b0);

    // sof arrives where (3,4) would have been.
    start_count(8'h00);
    send(3 * LW + 4, 8'h00, 1'b0, 1'b1);
    idle(1);
    chk("partial_win_count", 128'(widx), 128'(8));
    full_frame("midsof", 8'h80, 1'b0);

    // Reset asserted right after (2,5) is accepted.
    start_count(8'h00);
    send(2 * LW + 6, 8'h00, 1'b0, 1'b1);
    chk("pre_reset_valid", 128'(win_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("reset_async_zero", 128'({win, win_valid, win_col, row_update, frame_done}), 128'(0));
    chk("pre_reset_win_count", 128'(widx), 128'(3));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int k = 0; k < 15; k++) drive(8'(k), 1'b0);
    quiet = 1'b0;
    full_frame("after_reset", 8'h00, 1'b1);

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
